// File: rtl/axi_pkg.sv
// ============================================================================
// Module   : axi_pkg
// Brief    : Shared AXI4 constants, FSM encoding and sizing helper
// Revision : 1.0
// ============================================================================
`default_nettype none

package axi_pkg;

    localparam logic [1:0] AXI_BURST_INCR  = 2'b01;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
    localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

    localparam int AXI_4KB = 4096;

    typedef logic [1:0] axi_state_t;

    localparam axi_state_t ST_IDLE = 2'd0;
    localparam axi_state_t ST_ADDR = 2'd1;
    localparam axi_state_t ST_DATA = 2'd2;
    localparam axi_state_t ST_RESP = 2'd3;

    function automatic int axi_clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage

`default_nettype wire

// File: rtl/axi_burst_split.sv
// ============================================================================
// Module   : axi_burst_split
// Brief    : Combinational burst sizer: min(remaining, MAX_BURST, beats to 4KB)
// Revision : 1.0
// ============================================================================
`default_nettype none

module axi_burst_split
    import axi_pkg::*;
#(
    parameter int D_WIDTH   = 64,
    parameter int MAX_BURST = 16,
    parameter int CNT_W     = 16
) (
    input  logic [11:0]      i_addr_lo,
    input  logic [CNT_W-1:0] i_remaining,
    output logic [CNT_W-1:0] o_beats
);

    localparam int              c_size      = axi_clog2(D_WIDTH / 8);
    localparam logic [CNT_W-1:0] c_max_beats = CNT_W'(MAX_BURST);

    logic [12:0]      w_room_bytes;
    logic [CNT_W-1:0] w_room_beats;
    logic [CNT_W-1:0] w_capped;

    // Room is 1..4096 bytes, so 13 bits always holds it.
    assign w_room_bytes = 13'(AXI_4KB) - {1'b0, i_addr_lo};
    assign w_room_beats = CNT_W'(w_room_bytes >> c_size);

    always_comb begin
        w_capped = i_remaining;
        if (w_capped > c_max_beats) begin
            w_capped = c_max_beats;
        end
        o_beats = w_capped;
        if (w_capped > w_room_beats) begin
            o_beats = w_room_beats;
        end
    end

endmodule

`default_nettype wire

// File: rtl/axi_master_v4_write.sv
// ============================================================================
// Module   : axi_master_v4_write
// Brief    : AXI4 INCR write master, one burst in flight, W pass-through
// Revision : 1.0
// ============================================================================
`default_nettype none

module axi_master_v4_write
    import axi_pkg::*;
#(
    parameter int D_WIDTH   = 64,
    parameter int MAX_BURST = 16,
    parameter int LEN_W     = 16
) (
    input  logic                 sys_clock,
    input  logic                 async_reset,
    input  logic [31:0]          i_cmd_addr,
    input  logic [LEN_W-1:0]     i_cmd_beats,
    input  logic                 i_cmd_valid,
    output logic                 or_cmd_ready,
    input  logic [D_WIDTH-1:0]   i_data,
    input  logic                 i_data_valid,
    output logic                 o_data_ready,
    output logic                 or_done,
    output logic                 or_err,
    output logic [31:0]          or_aw_addr,
    output logic [7:0]           or_aw_len,
    output logic [2:0]           o_aw_size,
    output logic [1:0]           o_aw_burst,
    output logic                 or_aw_valid,
    input  logic                 i_aw_ready,
    output logic [D_WIDTH-1:0]   o_w_data,
    output logic [D_WIDTH/8-1:0] o_w_strb,
    output logic                 or_w_last,
    output logic                 o_w_valid,
    input  logic                 i_w_ready,
    input  logic [1:0]           i_b_resp,
    input  logic                 i_b_valid,
    output logic                 or_b_ready
);

    localparam int          c_bytes     = D_WIDTH / 8;
    localparam int          c_size      = axi_clog2(c_bytes);
    localparam int          c_cnt_w     = (LEN_W > 13) ? LEN_W : 13;
    localparam logic [31:0] c_addr_mask = ~32'(c_bytes - 1);

    axi_state_t         r_state_q,     w_state_d;
    logic [31:0]        r_addr_q,      w_addr_d;
    logic [c_cnt_w-1:0] r_rem_q,       w_rem_d;
    logic [c_cnt_w-1:0] r_burst_n_q,   w_burst_n_d;
    logic [7:0]         r_beat_q,      w_beat_d;
    logic [31:0]        r_aw_addr_q,   w_aw_addr_d;
    logic [7:0]         r_aw_len_q,    w_aw_len_d;
    logic               r_aw_valid_q,  w_aw_valid_d;
    logic               r_b_ready_q,   w_b_ready_d;
    logic               r_cmd_ready_q, w_cmd_ready_d;
    logic               r_done_q,      w_done_d;
    logic               r_err_q,       w_err_d;
    logic               r_w_last_q,    w_w_last_d;

    logic [31:0]        w_cmd_addr;
    logic [c_cnt_w-1:0] w_cmd_beats;
    logic [31:0]        w_addr_next;
    logic [c_cnt_w-1:0] w_rem_next;
    logic [31:0]        w_split_addr;
    logic [c_cnt_w-1:0] w_split_rem;
    logic [c_cnt_w-1:0] w_split_n;
    logic               w_in_data;
    logic               w_w_hs;
    logic               w_resp_err;
    logic               w_load;

    assign w_cmd_addr  = i_cmd_addr & c_addr_mask;
    assign w_cmd_beats = c_cnt_w'(i_cmd_beats);
    assign w_addr_next = r_addr_q + (32'(r_burst_n_q) << c_size);
    assign w_rem_next  = r_rem_q - r_burst_n_q;

    // The next burst is sized from whichever address/remaining pair is about to be latched.
    assign w_split_addr = (r_state_q == ST_IDLE) ? w_cmd_addr  : w_addr_next;
    assign w_split_rem  = (r_state_q == ST_IDLE) ? w_cmd_beats : w_rem_next;

    axi_burst_split #(
        .D_WIDTH   (D_WIDTH),
        .MAX_BURST (MAX_BURST),
        .CNT_W     (c_cnt_w)
    ) u_burst_split (
        .i_addr_lo   (w_split_addr[11:0]),
        .i_remaining (w_split_rem),
        .o_beats     (w_split_n)
    );

    assign w_in_data  = (r_state_q == ST_DATA);
    assign w_w_hs     = w_in_data && i_data_valid && i_w_ready;
    assign w_resp_err = (i_b_resp == AXI_RESP_SLVERR) || (i_b_resp == AXI_RESP_DECERR);

    always_comb begin
        w_state_d     = r_state_q;
        w_addr_d      = r_addr_q;
        w_rem_d       = r_rem_q;
        w_burst_n_d   = r_burst_n_q;
        w_beat_d      = r_beat_q;
        w_aw_addr_d   = r_aw_addr_q;
        w_aw_len_d    = r_aw_len_q;
        w_aw_valid_d  = r_aw_valid_q;
        w_b_ready_d   = r_b_ready_q;
        w_cmd_ready_d = r_cmd_ready_q;
        w_err_d       = r_err_q;
        w_w_last_d    = r_w_last_q;
        w_done_d      = 1'b0;
        w_load        = 1'b0;

        case (r_state_q)
            ST_IDLE: begin
                if (i_cmd_valid && r_cmd_ready_q) begin
                    if (w_cmd_beats == '0) begin
                        w_done_d = 1'b1;
                    end else begin
                        w_addr_d  = w_cmd_addr;
                        w_rem_d   = w_cmd_beats;
                        w_err_d   = 1'b0;
                        w_load    = 1'b1;
                        w_state_d = ST_ADDR;
                    end
                end
            end
            ST_ADDR: begin
                if (i_aw_ready) begin
                    w_aw_valid_d = 1'b0;
                    w_beat_d     = '0;
                    w_w_last_d   = (r_aw_len_q == 8'd0);
                    w_state_d    = ST_DATA;
                end
            end
            ST_DATA: begin
                if (w_w_hs) begin
                    if (r_w_last_q) begin
                        w_w_last_d  = 1'b0;
                        w_b_ready_d = 1'b1;
                        w_state_d   = ST_RESP;
                    end else begin
                        w_beat_d   = r_beat_q + 8'd1;
                        w_w_last_d = ((r_beat_q + 8'd1) == r_aw_len_q);
                    end
                end
            end
            ST_RESP: begin
                if (i_b_valid) begin
                    w_err_d     = r_err_q | w_resp_err;
                    w_addr_d    = w_addr_next;
                    w_rem_d     = w_rem_next;
                    w_b_ready_d = 1'b0;
                    if (w_rem_next == '0) begin
                        w_done_d      = 1'b1;
                        w_cmd_ready_d = 1'b1;
                        w_state_d     = ST_IDLE;
                    end else begin
                        w_load    = 1'b1;
                        w_state_d = ST_ADDR;
                    end
                end
            end
            default: begin
                w_state_d     = ST_IDLE;
                w_cmd_ready_d = 1'b1;
            end
        endcase

        if (w_load) begin
            w_burst_n_d   = w_split_n;
            w_aw_len_d    = 8'(w_split_n - c_cnt_w'(1));
            w_aw_addr_d   = w_split_addr;
            w_aw_valid_d  = 1'b1;
            w_cmd_ready_d = 1'b0;
        end
    end

    always_ff @(posedge sys_clock) begin
        if (async_reset) begin
            r_state_q     <= ST_IDLE;
            r_addr_q      <= '0;
            r_rem_q       <= '0;
            r_burst_n_q   <= '0;
            r_beat_q      <= '0;
            r_aw_addr_q   <= '0;
            r_aw_len_q    <= '0;
            r_aw_valid_q  <= 1'b0;
            r_b_ready_q   <= 1'b0;
            r_cmd_ready_q <= 1'b1;
            r_done_q      <= 1'b0;
            r_err_q       <= 1'b0;
            r_w_last_q    <= 1'b0;
        end else begin
            r_state_q     <= w_state_d;
            r_addr_q      <= w_addr_d;
            r_rem_q       <= w_rem_d;
            r_burst_n_q   <= w_burst_n_d;
            r_beat_q      <= w_beat_d;
            r_aw_addr_q   <= w_aw_addr_d;
            r_aw_len_q    <= w_aw_len_d;
            r_aw_valid_q  <= w_aw_valid_d;
            r_b_ready_q   <= w_b_ready_d;
            r_cmd_ready_q <= w_cmd_ready_d;
            r_done_q      <= w_done_d;
            r_err_q       <= w_err_d;
            r_w_last_q    <= w_w_last_d;
        end
    end

    assign or_cmd_ready = r_cmd_ready_q;
    assign or_done      = r_done_q;
    assign or_err       = r_err_q;
    assign or_aw_addr   = r_aw_addr_q;
    assign or_aw_len    = r_aw_len_q;
    assign or_aw_valid  = r_aw_valid_q;
    assign or_w_last    = r_w_last_q;
    assign or_b_ready   = r_b_ready_q;
    assign o_aw_size    = 3'(c_size);
    assign o_aw_burst   = AXI_BURST_INCR;

    // Data path is a straight wire; only the handshake is gated by state.
    assign o_w_data     = i_data;
    assign o_w_strb     = '1;
    assign o_w_valid    = w_in_data && i_data_valid;
    assign o_data_ready = w_in_data && i_w_ready;

endmodule

`default_nettype wire

// File: tb/tb_axi_master_v4_write.sv
// ============================================================================
// Module   : tb_axi_master_v4_write
// Brief    : Randomised self-checking bench for the AXI4 write master
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_axi_master_v4_write;

    localparam int D_WIDTH   = 64;
    localparam int MAX_BURST = 16;
    localparam int LEN_W     = 16;
    localparam int BYTES     = D_WIDTH / 8;

    logic                 sys_clock = 1'b0;
    logic                 async_reset;
    logic [31:0]          i_cmd_addr;
    logic [LEN_W-1:0]     i_cmd_beats;
    logic                 i_cmd_valid;
    logic                 or_cmd_ready;
    logic [D_WIDTH-1:0]   i_data;
    logic                 i_data_valid;
    logic                 o_data_ready;
    logic                 or_done;
    logic                 or_err;
    logic [31:0]          or_aw_addr;
    logic [7:0]           or_aw_len;
    logic [2:0]           o_aw_size;
    logic [1:0]           o_aw_burst;
    logic                 or_aw_valid;
    logic                 i_aw_ready;
    logic [D_WIDTH-1:0]   o_w_data;
    logic [D_WIDTH/8-1:0] o_w_strb;
    logic                 or_w_last;
    logic                 o_w_valid;
    logic                 i_w_ready;
    logic [1:0]           i_b_resp;
    logic                 i_b_valid;
    logic                 or_b_ready;

    always #5 sys_clock = ~sys_clock;

    axi_master_v4_write #(
        .D_WIDTH   (D_WIDTH),
        .MAX_BURST (MAX_BURST),
        .LEN_W     (LEN_W)
    ) dut (
        .sys_clock    (sys_clock),
        .async_reset  (async_reset),
        .i_cmd_addr   (i_cmd_addr),
        .i_cmd_beats  (i_cmd_beats),
        .i_cmd_valid  (i_cmd_valid),
        .or_cmd_ready (or_cmd_ready),
        .i_data       (i_data),
        .i_data_valid (i_data_valid),
        .o_data_ready (o_data_ready),
        .or_done      (or_done),
        .or_err       (or_err),
        .or_aw_addr   (or_aw_addr),
        .or_aw_len    (or_aw_len),
        .o_aw_size    (o_aw_size),
        .o_aw_burst   (o_aw_burst),
        .or_aw_valid  (or_aw_valid),
        .i_aw_ready   (i_aw_ready),
        .o_w_data     (o_w_data),
        .o_w_strb     (o_w_strb),
        .or_w_last    (or_w_last),
        .o_w_valid    (o_w_valid),
        .i_w_ready    (i_w_ready),
        .i_b_resp     (i_b_resp),
        .i_b_valid    (i_b_valid),
        .or_b_ready   (or_b_ready)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference: expected bursts and per-beat last flags
    logic [31:0] exp_aw_addr[$];
    logic [7:0]  exp_aw_len[$];
    bit          exp_last[$];

    // Observations gathered while driving one command
    logic [31:0] obs_aw_addr[$];
    logic [7:0]  obs_aw_len[$];
    logic [31:0] obs_seq[$];
    bit          obs_last[$];
    logic [31:0] obs_base;
    int          obs_stab_err;
    int          obs_early_w;
    int          obs_pass_err;
    bit          obs_done;
    int          obs_done_lat;
    logic        obs_err_at_done;
    logic        obs_err_after_hs;

    task automatic build_model(input logic [31:0] addr, input int beats);
        logic [31:0] a;
        int rem, room, n;
        exp_aw_addr.delete();
        exp_aw_len.delete();
        exp_last.delete();
        a   = addr & ~32'(BYTES - 1);
        rem = beats;
        while (rem > 0) begin
            room = (4096 - int'(a % 4096)) / BYTES;
            n    = rem;
            if (n > MAX_BURST) n = MAX_BURST;
            if (n > room)      n = room;
            exp_aw_addr.push_back(a);
            exp_aw_len.push_back(8'(n - 1));
            for (int k = 0; k < n; k++) exp_last.push_back(k == n - 1);
            a   = a + 32'(n * BYTES);
            rem = rem - n;
        end
    endtask

    // Entered just after a falling edge; returns just after the falling edge showing done.
    task automatic drive_cmd(input logic [31:0] addr, input int beats, input bit stall,
                             input int err_burst);
        logic [31:0] seq, pa;
        logic [7:0]  pl;
        bit hs, aw_pend;
        int hs_cyc, aw_cnt, b_cnt;
        obs_aw_addr.delete(); obs_aw_len.delete(); obs_seq.delete(); obs_last.delete();
        obs_stab_err = 0; obs_early_w = 0; obs_pass_err = 0;
        obs_done = 0; obs_done_lat = -1; obs_err_at_done = 1'bx; obs_err_after_hs = 1'bx;
        seq = $urandom; obs_base = seq;
        hs = 0; hs_cyc = 0; aw_cnt = 0; b_cnt = 0; aw_pend = 0; pa = '0; pl = '0;
        i_cmd_addr  = addr;
        i_cmd_beats = LEN_W'(beats);
        i_cmd_valid = 1'b1;
        for (int cyc = 0; cyc < 4000 && !obs_done; cyc++) begin
            if (cyc > 0) @(negedge sys_clock);
            if (hs) i_cmd_valid = 1'b0;
            i_aw_ready   = stall ? ($urandom_range(0, 2) != 0) : 1'b1;
            i_w_ready    = stall ? ($urandom_range(0, 2) != 0) : 1'b1;
            i_data_valid = stall ? ($urandom_range(0, 2) != 0) : 1'b1;
            i_b_valid    = stall ? ($urandom_range(0, 2) != 0) : 1'b1;
            if (b_cnt == err_burst) i_b_resp = {1'b1, 1'($urandom_range(0, 1))};
            else                    i_b_resp = {1'b0, 1'($urandom_range(0, 1))};
            i_data = {seq ^ 32'hDEAD_BEEF, seq};
            #1;
            if (hs && cyc == hs_cyc + 1) obs_err_after_hs = or_err;
            if (hs && or_done) begin
                obs_done        = 1;
                obs_done_lat    = cyc - hs_cyc;
                obs_err_at_done = or_err;
            end
            if (o_w_valid) begin
                if (o_w_data !== i_data) obs_pass_err++;
                if (aw_cnt == b_cnt)     obs_early_w++;
            end
            if (o_w_valid && o_data_ready) begin
                obs_seq.push_back(seq);
                obs_last.push_back(or_w_last);
                seq = seq + 32'd1;
            end
            if (or_aw_valid) begin
                if (aw_pend && (or_aw_addr !== pa || or_aw_len !== pl)) obs_stab_err++;
                pa = or_aw_addr;
                pl = or_aw_len;
                aw_pend = !i_aw_ready;
                if (i_aw_ready) begin
                    obs_aw_addr.push_back(or_aw_addr);
                    obs_aw_len.push_back(or_aw_len);
                    aw_cnt++;
                end
            end else begin
                aw_pend = 0;
            end
            if (or_b_ready && i_b_valid) b_cnt++;
            if (i_cmd_valid && or_cmd_ready && !hs) begin
                hs = 1;
                hs_cyc = cyc;
            end
        end
        i_cmd_valid = 1'b0;
    endtask

    task automatic run_and_check(input string name, input logic [31:0] addr, input int beats,
                                 input bit stall, input int err_burst, input logic exp_err,
                                 input bit chk_pulse);
        build_model(addr, beats);
        drive_cmd(addr, beats, stall, err_burst);
        n_cmp++;
        if (obs_done !== 1'b1) begin
            n_fail++;
            $display("FAIL %s done_timeout: got done=%0b, required 1", name, obs_done);
        end
        n_cmp++;
        if (obs_aw_addr.size() != exp_aw_addr.size()) begin
            n_fail++;
            $display("FAIL %s aw_count: got %0d, required %0d", name, obs_aw_addr.size(),
                     exp_aw_addr.size());
        end
        for (int i = 0; i < obs_aw_addr.size() && i < exp_aw_addr.size(); i++) begin
            n_cmp++;
            if (obs_aw_addr[i] !== exp_aw_addr[i] || obs_aw_len[i] !== exp_aw_len[i]) begin
                n_fail++;
                $display("FAIL %s aw[%0d]: got addr=%h len=%0d, required addr=%h len=%0d", name,
                         i, obs_aw_addr[i], obs_aw_len[i], exp_aw_addr[i], exp_aw_len[i]);
            end
        end
        n_cmp++;
        if (obs_seq.size() != beats) begin
            n_fail++;
            $display("FAIL %s beat_count: got %0d, required %0d", name, obs_seq.size(), beats);
        end
        for (int i = 0; i < obs_seq.size() && i < exp_last.size(); i++) begin
            n_cmp++;
            if (obs_seq[i] !== obs_base + 32'(i) || obs_last[i] !== exp_last[i]) begin
                n_fail++;
                $display("FAIL %s beat[%0d]: got data=%h last=%0b, required data=%h last=%0b",
                         name, i, obs_seq[i], obs_last[i], obs_base + 32'(i), exp_last[i]);
            end
        end
        n_cmp++;
        if (obs_stab_err != 0 || obs_early_w != 0 || obs_pass_err != 0) begin
            n_fail++;
            $display("FAIL %s protocol: got aw_unstable=%0d w_before_aw=%0d wdata_diff=%0d, required 0/0/0",
                     name, obs_stab_err, obs_early_w, obs_pass_err);
        end
        n_cmp++;
        if (obs_err_at_done !== exp_err) begin
            n_fail++;
            $display("FAIL %s err_at_done: got %b, required %b", name, obs_err_at_done, exp_err);
        end
        if (beats > 0) begin
            n_cmp++;
            if (obs_err_after_hs !== 1'b0) begin
                n_fail++;
                $display("FAIL %s err_clear: got %b, required 0", name, obs_err_after_hs);
            end
        end else begin
            n_cmp++;
            if (obs_done_lat != 1) begin
                n_fail++;
                $display("FAIL %s done_latency: got %0d, required 1", name, obs_done_lat);
            end
        end
        if (chk_pulse) begin
            @(negedge sys_clock);
            #1;
            n_cmp++;
            if (or_done !== 1'b0) begin
                n_fail++;
                $display("FAIL %s done_width: got done=%b a cycle later, required 0", name, or_done);
            end
        end
    endtask

    task automatic test_reset();
        async_reset  = 1'b1;
        i_data_valid = 1'b1;
        i_w_ready    = 1'b1;
        repeat (3) @(negedge sys_clock);
        #1;
        n_cmp++;
        if (or_cmd_ready !== 1'b1 || or_aw_valid !== 1'b0 || or_b_ready !== 1'b0 ||
            or_done !== 1'b0 || or_err !== 1'b0 || or_w_last !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: got rdy=%b awv=%b bry=%b done=%b err=%b last=%b, required 1 0 0 0 0 0",
                     or_cmd_ready, or_aw_valid, or_b_ready, or_done, or_err, or_w_last);
        end
        n_cmp++;
        if (or_aw_addr !== 32'd0 || or_aw_len !== 8'd0 || o_w_valid !== 1'b0 || o_data_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_data: got addr=%h len=%h wv=%b drdy=%b, required 0 0 0 0",
                     or_aw_addr, or_aw_len, o_w_valid, o_data_ready);
        end
        n_cmp++;
        if (o_aw_size !== 3'd3 || o_aw_burst !== 2'b01 || o_w_strb !== 8'hFF) begin
            n_fail++;
            $display("FAIL constants: got size=%0d burst=%b strb=%h, required 3 01 ff",
                     o_aw_size, o_aw_burst, o_w_strb);
        end
        @(negedge sys_clock);
        async_reset = 1'b0;
    endtask

    task automatic test_single();
        run_and_check("single", 32'h1000, 4, 1'b0, -1, 1'b0, 1'b1);
        n_cmp++;
        if (obs_aw_addr.size() != 1 || obs_aw_addr[0] !== 32'h1000 || obs_aw_len[0] !== 8'd3) begin
            n_fail++;
            $display("FAIL single_aw: got %0d bursts first addr=%h len=%0d, required 1 burst 00001000 len 3",
                     obs_aw_addr.size(), obs_aw_addr[0], obs_aw_len[0]);
        end
    endtask

    task automatic test_multi();
        run_and_check("multi", 32'h0, 40, 1'b0, -1, 1'b0, 1'b0);
        n_cmp++;
        if (obs_aw_addr.size() != 3 || obs_aw_addr[0] !== 32'h000 || obs_aw_len[0] !== 8'd15 ||
            obs_aw_addr[1] !== 32'h080 || obs_aw_len[1] !== 8'd15 ||
            obs_aw_addr[2] !== 32'h100 || obs_aw_len[2] !== 8'd7) begin
            n_fail++;
            $display("FAIL multi_aw: got %0d bursts, required (000,15)(080,15)(100,7)",
                     obs_aw_addr.size());
        end
    endtask

    task automatic test_4kb();
        run_and_check("cross4k", 32'h0FE0, 8, 1'b0, -1, 1'b0, 1'b0);
        n_cmp++;
        if (obs_aw_addr.size() != 2 || obs_aw_addr[0] !== 32'h0FE0 || obs_aw_len[0] !== 8'd3 ||
            obs_aw_addr[1] !== 32'h1000 || obs_aw_len[1] !== 8'd3) begin
            n_fail++;
            $display("FAIL cross4k_aw: got %0d bursts, required (0fe0,3)(1000,3)", obs_aw_addr.size());
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] addr;
        int beats;
        for (int i = 0; i < 8; i++) begin
            addr = $urandom & ~32'(BYTES - 1);
            if (i % 2 == 1) addr = (addr & ~32'hFFF) | (32'hF80 + 32'($urandom_range(0, 15)) * 8);
            beats = $urandom_range(1, 60);
            run_and_check("backpressure", addr, beats, 1'b1, -1, 1'b0, 1'b0);
        end
    endtask

    task automatic test_error();
        run_and_check("slverr", 32'h0, 40, 1'b1, 1, 1'b1, 1'b0);
        run_and_check("err_clear", 32'h200, 4, 1'b0, -1, 1'b0, 1'b0);
    endtask

    task automatic test_zero_beats();
        run_and_check("zero_beats", 32'h40, 0, 1'b0, -1, 1'b0, 1'b1);
    endtask

    task automatic test_back_to_back();
        run_and_check("b2b_first", 32'h3000, 5, 1'b0, -1, 1'b0, 1'b0);
        run_and_check("b2b_second", 32'h3FF0, 6, 1'b0, -1, 1'b0, 1'b0);
    endtask

    task automatic test_reset_mid();
        bit found;
        found = 0;
        @(negedge sys_clock);
        i_cmd_addr   = 32'h0;
        i_cmd_beats  = LEN_W'(8);
        i_cmd_valid  = 1'b1;
        i_aw_ready   = 1'b1;
        i_w_ready    = 1'b1;
        i_data_valid = 1'b0;
        i_b_valid    = 1'b0;
        @(negedge sys_clock);
        i_cmd_valid = 1'b0;
        for (int c = 0; c < 20; c++) begin
            #1;
            if (o_data_ready) begin
                found = 1;
                break;
            end
            @(negedge sys_clock);
        end
        n_cmp++;
        if (!found) begin
            n_fail++;
            $display("FAIL reset_mid_reach_data: got data_ready never high, required high within 20 cycles");
        end
        async_reset  = 1'b1;
        i_data_valid = 1'b1;
        @(negedge sys_clock);
        #1;
        n_cmp++;
        if (or_cmd_ready !== 1'b1 || or_aw_valid !== 1'b0 || o_w_valid !== 1'b0 ||
            o_data_ready !== 1'b0 || or_b_ready !== 1'b0 || or_w_last !== 1'b0 ||
            or_done !== 1'b0 || or_aw_len !== 8'd0 || or_aw_addr !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_mid: got rdy=%b awv=%b wv=%b drdy=%b bry=%b last=%b done=%b len=%h, required 1 0 0 0 0 0 0 00",
                     or_cmd_ready, or_aw_valid, o_w_valid, o_data_ready, or_b_ready, or_w_last,
                     or_done, or_aw_len);
        end
        async_reset  = 1'b0;
        i_data_valid = 1'b0;
        run_and_check("after_reset", 32'h5000, 3, 1'b0, -1, 1'b0, 1'b0);
    endtask

    initial begin
        async_reset  = 1'b1;
        i_cmd_addr   = '0;
        i_cmd_beats  = '0;
        i_cmd_valid  = 1'b0;
        i_data       = '0;
        i_data_valid = 1'b0;
        i_aw_ready   = 1'b0;
        i_w_ready    = 1'b0;
        i_b_resp     = 2'b00;
        i_b_valid    = 1'b0;

        test_reset();
        test_single();
        test_multi();
        test_4kb();
        test_backpressure();
        test_error();
        test_zero_beats();
        test_back_to_back();
        test_reset_mid();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/axi_master_v4_write.md
Name: axi_master_v4_write

Overview:
AXI4 write master, the counterpart of the team's aligned AXI4 read master. Accepts a command (start address, beat count) plus a user data stream, and issues INCR write bursts on AW/W/B. Bursts never cross a 4 KB boundary and never exceed MAX_BURST beats. One burst is outstanding at a time; the data path is a combinational pass-through with no buffering.

Parameters:
D_WIDTH, 64, data bus width in bits (power of 2, 32..1024)
MAX_BURST, 16, maximum beats per burst (1..256)
LEN_W, 16, width of the command beat count

Ports:
sys_clock  in  1  clock
async_reset  in  1  reset, synchronous, active-high
i_cmd_addr  in  32  start byte address, aligned to D_WIDTH/8
i_cmd_beats  in  LEN_W  total beats to write
i_cmd_valid  in  1  command valid
or_cmd_ready  out  1  command accepted when high with i_cmd_valid
i_data  in  D_WIDTH  user write data
i_data_valid  in  1  user data valid
o_data_ready  out  1  user data consumed when high with i_data_valid
or_done  out  1  one-cycle pulse when the command completes
or_err  out  1  sticky: some B response was SLVERR or DECERR
or_aw_addr  out  32  burst address
or_aw_len  out  8  beats-1
o_aw_size  out  3  constant log2(D_WIDTH/8)
o_aw_burst  out  2  constant INCR (2'b01)
or_aw_valid  out  1  AW valid
i_aw_ready  in  1  AW ready
o_w_data  out  D_WIDTH  equals i_data
o_w_strb  out  D_WIDTH/8  all ones
or_w_last  out  1  last beat of burst
o_w_valid  out  1  W valid
i_w_ready  in  1  W ready
i_b_resp  in  2  write response
i_b_valid  in  1  B valid
or_b_ready  out  1  B ready

Behaviour:
- Reset: FSM to IDLE. or_cmd_ready=1; or_aw_valid, or_b_ready, or_done, or_err and or_w_last all 0; or_aw_addr and or_aw_len 0; internal counters 0.
- States: IDLE, ADDR, DATA, RESP.
- IDLE:
  - or_cmd_ready=1.
  - On cmd handshake with beats=0: stay IDLE and pulse or_done next cycle; no AXI traffic.
  - On cmd handshake with beats>0: latch addr/remaining, clear or_err, go to ADDR.
  - or_cmd_ready=0 in every other state.
- Burst sizing (registered on entry to ADDR):
  - n = min(remaining, MAX_BURST, (4096 - addr[11:0])/(D_WIDTH/8)).
  - or_aw_len = n-1; or_aw_addr = current addr.
  - or_aw_valid rises the cycle after the cmd handshake, or the cycle after the previous B handshake.
- ADDR:
  - or_aw_valid held high with addr/len stable until i_aw_ready, then go to DATA and deassert.
- DATA:
  - o_w_valid = i_data_valid; o_data_ready = i_w_ready; both forced 0 outside DATA.
  - Beat counter increments on each W handshake.
  - or_w_last is high when counter == or_aw_len, including the first beat when len=0.
  - After the handshake with last=1, go to RESP.
- RESP:
  - or_b_ready=1.
  - On i_b_valid: set or_err if i_b_resp[1]; addr += n*(D_WIDTH/8); remaining -= n.
  - remaining==0 -> IDLE with or_done=1 for exactly one cycle (the first IDLE cycle); else -> ADDR.
- W data is never presented before the AW handshake; this is AXI-legal.
- Arithmetic:
  - Address adds are 32-bit and wrap at 2^32 (caller's responsibility).
  - All beat and burst arithmetic uses width max(LEN_W, 13).
- Unaligned i_cmd_addr: low bits are forced to 0 in or_aw_addr; behaviour is otherwise undefined.
- Reset mid-operation: immediate return to IDLE with all outputs at reset values. The partially issued burst is abandoned; the interconnect must be reset together with this block.
- Simultaneous i_cmd_valid and pending or_done: no conflict, because done is asserted in IDLE with or_cmd_ready=1 and a new command may be accepted that same cycle.

Decomposition:
- Shared package axi_pkg: AXI_BURST_INCR, AXI_RESP_OKAY/EXOKAY/SLVERR/DECERR, AXI_4KB=4096, state enum, clog2 helper for o_aw_size.
- One sub-module, axi_burst_split: combinational, computes n from addr, remaining and MAX_BURST. It is shareable with the read master.

Test Plan:
- Single burst: addr 0x1000, beats 4, all ready high -> one AW (addr 0x1000, len 3), 4 W beats with last on the 4th, one B, or_done pulse, or_err=0.
- Multi-burst: addr 0x0, beats 40, MAX_BURST 16 -> AW sequence (0x000, len15), (0x080, len15), (0x100, len7); exactly 40 data beats consumed.
- 4 KB crossing: addr 0x0FE0, beats 8, D_WIDTH 64 -> AW (0x0FE0, len3) then AW (0x1000, len3).
- Backpressure: random i_w_ready/i_data_valid/i_aw_ready stalls -> aw_addr/len stable while valid; no beat lost or duplicated (data checked by incrementing pattern); last flag aligned.
- Error: SLVERR on second of three bursts -> all three bursts still complete, or_err=1 at done, or_err cleared on next command.
- Boundary: beats=0 -> or_done one cycle later, no AW. Reset asserted mid-DATA -> next cycle or_cmd_ready=1 and all valid outputs 0.
